// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Optional feature macro used by this slice: FETCH_PERF_CNT_EN.
package fetch_pkg;
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the imem, redirect and decode-side signals of the fetch unit.
// Perf counter outputs exist only when FETCH_PERF_CNT_EN is defined.
interface instr_fetch_unit_if #(
  parameter int XLEN    = 32,
  parameter int IMEM_AW = 10
) ();
  logic               imem_req_o;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_rdata_i;
  logic               redirect_i;
  logic [XLEN-1:0]    redirect_pc_i;
  logic               instr_valid_o;
  logic               instr_ready_i;
  logic [31:0]        instr_o;
  logic [XLEN-1:0]    instr_pc_o;
  logic [5:0]         opcode_o;
  logic [5:0]         funct_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        perf_fetched_o;
  logic [31:0]        perf_stall_o;
`endif

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_rdata_i,
    input  redirect_i, redirect_pc_i,
    output instr_valid_o,
    input  instr_ready_i,
    output instr_o, instr_pc_o, opcode_o, funct_o
`ifdef FETCH_PERF_CNT_EN
    , output perf_fetched_o, perf_stall_o
`endif
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_rdata_i,
    output redirect_i, redirect_pc_i,
    input  instr_valid_o,
    output instr_ready_i,
    input  instr_o, instr_pc_o, opcode_o, funct_o
`ifdef FETCH_PERF_CNT_EN
    , input perf_fetched_o, perf_stall_o
`endif
  );
endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of packed {word,pc} entries with synchronous clear.
// Clear beats any same-cycle push or pop.
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [W-1:0] mem_d [FIFO_DEPTH];
  logic         rd_q, rd_d, wr_q, wr_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = 1'b0;
      wr_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_q] = din;
        wr_d        = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// PC sequencer + imem request logic feeding decode through a 2-entry FIFO.
// FETCH_PERF_CNT_EN adds saturating transfer/stall counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              IMEM_AW  = 10
) (
  input logic              clk,
  input logic              rst,
  instr_fetch_unit_if.master io
);
  localparam int EW = 32 + XLEN;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] issue_pc_q, issue_pc_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     hold_word_q, hold_word_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;

  logic            issue, push, pop, valid;
  logic [1:0]      fifo_cnt;
  logic [2:0]      occ;
  logic [EW-1:0]   head;

  fetch_skid_fifo #(.W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (io.redirect_i),
    .din   ({io.imem_rdata_i, issue_pc_q}),
    .dout  (head),
    .count (fifo_cnt)
  );

  assign valid = (fifo_cnt != 2'd0);
  assign pop   = valid & io.instr_ready_i;
  // A response landing in the redirect cycle is stale and never enters the FIFO.
  assign push  = inflight_q & ~io.redirect_i;
  // Counting the departing head as free lets a fetch issue every cycle under ready=1.
  assign occ   = {1'b0, fifo_cnt} - {2'b0, pop} + {2'b0, inflight_q};
  assign issue = (state_q == RUN) & ~io.redirect_i & (occ < 3'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issue_pc_d  = issue_pc_q;
    inflight_d  = issue;
    hold_word_d = hold_word_q;
    hold_pc_d   = hold_pc_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (issue) begin
      pc_d       = pc_q + XLEN'(4);
      issue_pc_d = pc_q;
    end
    if (io.redirect_i) begin
      state_d = FLUSH;
      pc_d    = io.redirect_pc_i & ~XLEN'(3);
    end
    if (valid) begin
      hold_word_d = head[EW-1:XLEN];
      hold_pc_d   = head[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      issue_pc_q  <= '0;
      inflight_q  <= 1'b0;
      hold_word_q <= NOP;
      hold_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issue_pc_q  <= issue_pc_d;
      inflight_q  <= inflight_d;
      hold_word_q <= hold_word_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

  assign io.imem_req_o    = issue;
  assign io.imem_addr_o   = pc_q[IMEM_AW+1:2];
  assign io.instr_valid_o = valid;
  assign io.instr_o       = valid ? head[EW-1:XLEN] : hold_word_q;
  assign io.instr_pc_o    = valid ? head[XLEN-1:0]  : hold_pc_q;
  assign io.opcode_o      = io.instr_o[OPC_MSB:OPC_LSB];
  assign io.funct_o       = io.instr_o[FUNCT_MSB:FUNCT_LSB];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (pop && perf_fetched_q != '1) perf_fetched_d = perf_fetched_q + 32'd1;
    if (valid && !io.instr_ready_i && perf_stall_q != '1)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign io.perf_fetched_o = perf_fetched_q;
  assign io.perf_stall_o   = perf_stall_q;
`endif
endmodule
